// File: rtl/sysram_portb_arb.sv
// Port-B arbiter for the system RAM: round-robin between host write, UART write and
// C2H readback, with a registered RAM drive and a fixed-latency read-return pipeline.
module sysram_portb_arb #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_cpu,
  input  logic          rstn,
  input  logic          en,
  input  logic          h_req,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_data,
  output logic          h_gnt,
  input  logic          u_req,
  input  logic [AW-1:0] u_addr,
  input  logic [DW-1:0] u_data,
  output logic          u_gnt,
  input  logic          r_req,
  input  logic [AW-1:0] r_addr,
  output logic          r_gnt,
  output logic [DW-1:0] r_data,
  output logic          r_vld,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  // ptr_q names the requester searched first in the next decision cycle
  typedef enum logic [1:0] {
    SelHost = 2'd0,
    SelUart = 2'd1,
    SelRead = 2'd2
  } sel_e;

  sel_e            ptr_q, ptr_d;
  logic [2:0]      gnt;  // {read, uart, host}
  logic [3:0]      wen_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic [DW-1:0]   rdata_q;
  logic            rvld_q;
  logic [RD_LAT:0] rd_sr_q;

  // Grant decision; gated by rstn so grants vanish immediately under reset
  always_comb begin
    gnt = 3'b000;
    if (en && rstn) begin
      unique case (ptr_q)
        SelHost: begin
          if (h_req)      gnt = 3'b001;
          else if (u_req) gnt = 3'b010;
          else if (r_req) gnt = 3'b100;
        end
        SelUart: begin
          if (u_req)      gnt = 3'b010;
          else if (r_req) gnt = 3'b100;
          else if (h_req) gnt = 3'b001;
        end
        SelRead: begin
          if (r_req)      gnt = 3'b100;
          else if (h_req) gnt = 3'b001;
          else if (u_req) gnt = 3'b010;
        end
        default: gnt = 3'b000;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = SelUart;
    else if (gnt[1]) ptr_d = SelRead;
    else if (gnt[2]) ptr_d = SelHost;
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= SelHost;
      wen_q   <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      rd_sr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      wen_q <= (gnt[0] || gnt[1]) ? 4'hF : 4'h0;
      if (gnt[0]) begin
        addr_q <= h_addr;
        din_q  <= h_data;
      end else if (gnt[1]) begin
        addr_q <= u_addr;
        din_q  <= u_data;
      end else if (gnt[2]) begin
        addr_q <= r_addr;
      end
      // Stage k set means a read whose address was driven k cycles ago
      rd_sr_q <= {rd_sr_q[RD_LAT-1:0], gnt[2]};
      rvld_q  <= rd_sr_q[RD_LAT];
      if (rd_sr_q[RD_LAT]) rdata_q <= ram_dout;
    end
  end

  always_comb begin
    h_gnt    = gnt[0];
    u_gnt    = gnt[1];
    r_gnt    = gnt[2];
    ram_wen  = wen_q;
    ram_addr = addr_q;
    ram_din  = din_q;
    r_data   = rdata_q;
    r_vld    = rvld_q;
    busy     = |rd_sr_q;
  end

endmodule

// File: tb/tb_sysram_portb_arb.sv
// Bench for sysram_portb_arb: hand-built grant table, directed corner sequences and
// randomized traffic checked against a queue-based cycle model of the arbiter.
module tb_sysram_portb_arb;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  logic          clk_cpu = 1'b0;
  logic          rstn;
  logic          en;
  logic          h_req, u_req, r_req;
  logic [AW-1:0] h_addr, u_addr, r_addr;
  logic [DW-1:0] h_data, u_data;
  logic          h_gnt, u_gnt, r_gnt;
  logic [DW-1:0] r_data;
  logic          r_vld;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;

  always #5 clk_cpu = ~clk_cpu;

  sysram_portb_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_cpu (clk_cpu),
    .rstn    (rstn),
    .en      (en),
    .h_req   (h_req),
    .h_addr  (h_addr),
    .h_data  (h_data),
    .h_gnt   (h_gnt),
    .u_req   (u_req),
    .u_addr  (u_addr),
    .u_data  (u_data),
    .u_gnt   (u_gnt),
    .r_req   (r_req),
    .r_addr  (r_addr),
    .r_gnt   (r_gnt),
    .r_data  (r_data),
    .r_vld   (r_vld),
    .ram_wen (ram_wen),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_dout(ram_dout),
    .busy    (busy)
  );

  // RAM: returns address + 0x1000, RD_LAT cycles after the address is driven
  logic [AW-1:0] dl [RD_LAT];
  always @(posedge clk_cpu) begin
    dl[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
  end
  assign ram_dout = DW'(dl[RD_LAT-1]) + 32'h1000;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, expected RAM drive, outstanding reads with grant cycle
  typedef struct {
    int            gcyc;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rdq[$];
  int            m_ptr;
  int            m_g = -1;
  int            cyc = 0;
  logic          m_rvld;
  logic [3:0]    m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_rdata;

  task automatic model_reset();
    m_ptr   = 0;
    m_g     = -1;
    m_wen   = 4'h0;
    m_addr  = '0;
    m_din   = '0;
    m_rdata = '0;
    rdq.delete();
  endtask

  task automatic model_check();
    logic [2:0] reqv;
    logic       busy_e;
    int         g;
    reqv = {r_req, u_req, h_req};
    g = -1;
    if (en && rstn) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        k = (m_ptr + i) % 3;
        if (g < 0 && reqv[k]) g = k;
      end
    end
    m_g = g;
    m_rvld = (rdq.size() > 0) && (rdq[0].gcyc + 2 + RD_LAT == cyc);
    busy_e = 1'b0;
    foreach (rdq[i])
      if (cyc >= rdq[i].gcyc + 1 && cyc <= rdq[i].gcyc + 1 + RD_LAT) busy_e = 1'b1;
    chk("h_gnt", h_gnt, g == 0);
    chk("u_gnt", u_gnt, g == 1);
    chk("r_gnt", r_gnt, g == 2);
    chk("ram_wen", ram_wen, m_wen);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_din", ram_din, m_din);
    chk("r_vld", r_vld, m_rvld);
    chk("r_data", r_data, m_rvld ? rdq[0].data : m_rdata);
    chk("busy", busy, busy_e);
  endtask

  task automatic model_advance();
    if (m_rvld) begin
      m_rdata = rdq[0].data;
      void'(rdq.pop_front());
    end
    if (m_g == 0) begin
      m_wen = 4'hF; m_addr = h_addr; m_din = h_data;
    end else if (m_g == 1) begin
      m_wen = 4'hF; m_addr = u_addr; m_din = u_data;
    end else if (m_g == 2) begin
      m_wen = 4'h0; m_addr = r_addr;
      rdq.push_back('{cyc, DW'(r_addr) + 32'h1000});
    end else begin
      m_wen = 4'h0;
    end
    if (m_g >= 0) m_ptr = (m_g + 1) % 3;
    cyc++;
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are sampled at the falling edge
  task automatic cyc_begin();
    @(negedge clk_cpu);
    model_check();
  endtask

  task automatic cyc_end();
    model_advance();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic idle(input int n);
    h_req = 0; u_req = 0; r_req = 0; en = 1;
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  typedef struct {
    logic       en;
    logic       h, u, r;
    logic [2:0] gnt;  // {r,u,h}
    logic [3:0] wen;
  } vec_t;

  vec_t tbl[16];
  int   vld_idx[$];
  logic [DW-1:0] vld_dat[$];
  int   prev_g;

  initial begin
    // Grant table from reset (host searched first); wen is the drive from the prior row
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 4'hF};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 4'hF};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 4'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 4'hF};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 4'hF};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 4'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 4'hF};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 4'hF};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 4'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 4'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 4'hF};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 4'hF};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'hF};

    rstn = 0; en = 1;
    h_req = 1; u_req = 0; r_req = 0;
    h_addr = '0; u_addr = '0; r_addr = '0; h_data = '0; u_data = '0;
    repeat (3) @(posedge clk_cpu);
    #1;
    chk("rst_h_gnt", h_gnt, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_rvld", r_vld, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_busy", busy, 0);
    h_req = 0;
    rstn = 1;
    model_reset();

    foreach (tbl[i]) begin
      en = tbl[i].en; h_req = tbl[i].h; u_req = tbl[i].u; r_req = tbl[i].r;
      h_addr = 16'(16'h100 + i); u_addr = 16'(16'h200 + i); r_addr = 16'(16'h300 + i);
      h_data = $urandom; u_data = $urandom;
      cyc_begin();
      chk("tbl_gnt", {r_gnt, u_gnt, h_gnt}, tbl[i].gnt);
      chk("tbl_wen", ram_wen, tbl[i].wen);
      cyc_end();
    end
    idle(6);

    // Single host write
    h_req = 1; h_addr = 16'h0010; h_data = 32'hDEADBEEF;
    cyc_begin(); chk("hw_gnt", h_gnt, 1); cyc_end();
    h_req = 0;
    cyc_begin();
    chk("hw_wen", ram_wen, 4'hF); chk("hw_addr", ram_addr, 16'h0010);
    chk("hw_din", ram_din, 32'hDEADBEEF);
    cyc_end();
    cyc_begin(); chk("hw_wen_off", ram_wen, 4'h0); cyc_end();
    idle(4);

    // Single readback
    r_req = 1; r_addr = 16'h0005;
    cyc_begin(); chk("rd_gnt", r_gnt, 1); cyc_end();
    r_req = 0;
    cyc_begin(); chk("rd_busy1", busy, 1); chk("rd_wen", ram_wen, 0); cyc_end();
    cyc_begin(); chk("rd_busy2", busy, 1); chk("rd_vld2", r_vld, 0); cyc_end();
    cyc_begin();
    chk("rd_vld3", r_vld, 1); chk("rd_data3", r_data, 32'h00001005); chk("rd_busy3", busy, 0);
    cyc_end();
    cyc_begin(); chk("rd_vld4", r_vld, 0); chk("rd_hold4", r_data, 32'h00001005); cyc_end();
    idle(3);

    // Four back-to-back reads
    for (int k = 0; k < 16; k++) begin
      r_req = (k < 4); r_addr = 16'(k);
      cyc_begin();
      if (k < 4) chk("b2b_gnt", r_gnt, 1);
      if (r_vld) begin vld_idx.push_back(k); vld_dat.push_back(r_data); end
      cyc_end();
    end
    chk("b2b_count", vld_idx.size(), 4);
    if (vld_idx.size() == 4) begin
      chk("b2b_consec", vld_idx[3] - vld_idx[0], 3);
      for (int i = 0; i < 4; i++) chk("b2b_data", vld_dat[i], 32'h1000 + i);
    end
    idle(2);

    // Enable held low blocks grants; rising enable grants in the same cycle
    en = 0; h_req = 1; h_addr = 16'h0042; h_data = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      cyc_begin(); chk("en0_gnt", h_gnt, 0); chk("en0_wen", ram_wen, 0); cyc_end();
    end
    en = 1;
    cyc_begin(); chk("en1_gnt", h_gnt, 1); cyc_end();
    idle(3);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      prev_g = m_g;
      en = ($urandom_range(0, 9) != 0);
      if (!h_req || prev_g == 0 || $urandom_range(0, 15) == 0) begin
        h_req = ($urandom_range(0, 2) == 0); h_addr = 16'($urandom); h_data = $urandom;
      end
      if (!u_req || prev_g == 1 || $urandom_range(0, 15) == 0) begin
        u_req = ($urandom_range(0, 2) == 0); u_addr = 16'($urandom); u_data = $urandom;
      end
      if (!r_req || prev_g == 2 || $urandom_range(0, 15) == 0) begin
        r_req = ($urandom_range(0, 2) == 0); r_addr = 16'($urandom);
      end
      cyc_begin();
      cyc_end();
    end
    idle(6);

    // Read granted, then reset before its return: no r_vld may ever appear
    r_req = 1; r_addr = 16'h0077;
    cyc_begin(); chk("rr_gnt", r_gnt, 1); cyc_end();
    r_req = 0; h_req = 1; h_addr = 16'h0abc; h_data = 32'hCAFEF00D;
    #2 rstn = 0;
    #1;
    chk("rr_h_gnt", h_gnt, 0);
    chk("rr_wen", ram_wen, 0);
    chk("rr_addr", ram_addr, 0);
    chk("rr_din", ram_din, 0);
    chk("rr_rvld", r_vld, 0);
    chk("rr_rdata", r_data, 0);
    chk("rr_busy", busy, 0);
    @(posedge clk_cpu);
    #1;
    rstn = 1;
    model_reset();
    cyc_begin(); chk("rr_first_gnt", h_gnt, 1); cyc_end();
    h_req = 0;
    for (int k = 0; k < 8; k++) begin
      cyc_begin(); chk("rr_no_vld", r_vld, 0); cyc_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
